// File: rtl/mul_exerciser_pkg.sv
// Shared types and width helpers for the multiplier exerciser.
package mul_exerciser_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StDone
    } state_e;

    localparam int unsigned ErrCntWidth = 8;
    localparam logic [ErrCntWidth-1:0] ErrCntMax = '1;

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_exr_vecgen.sv
// Operand sweep counters (x inner, y outer) and the reference product for the current vector.
module mul_exr_vecgen
    import mul_exerciser_pkg::*;
#(
    parameter int unsigned X_WIDTH = 3,
    parameter int unsigned Y_WIDTH = 3,
    parameter int unsigned P_WIDTH = 6,
    parameter bit          SIGNED  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               last,
    output logic [P_WIDTH-1:0] exp_p,
    output logic               exp_s
);

    localparam int unsigned FullW = max_width(X_WIDTH + Y_WIDTH, P_WIDTH + 1);

    logic [FullW-1:0]   x_ext;
    logic [FullW-1:0]   y_ext;
    logic [P_WIDTH:0]   prod;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x == '1) begin
                x <= '0;
                y <= y + Y_WIDTH'(1);
            end else begin
                x <= x + X_WIDTH'(1);
            end
        end
    end

    // Extending to the full width first makes the low bits of the product correct for
    // both signed and unsigned operands.
    always_comb begin
        if (SIGNED) begin
            x_ext = {{(FullW - X_WIDTH){x[X_WIDTH-1]}}, x};
            y_ext = {{(FullW - Y_WIDTH){y[Y_WIDTH-1]}}, y};
        end else begin
            x_ext = {{(FullW - X_WIDTH){1'b0}}, x};
            y_ext = {{(FullW - Y_WIDTH){1'b0}}, y};
        end
        prod = (P_WIDTH + 1)'(x_ext * y_ext);
    end

    assign exp_p = prod[P_WIDTH-1:0];
    assign exp_s = prod[P_WIDTH];
    assign last  = (x == '1) && (y == '1);

endmodule

// File: rtl/mul_exerciser.sv
// Exhaustive operand sweep of a multiplier core: restart per vector, wait, compare, count errors.
module mul_exerciser
    import mul_exerciser_pkg::*;
#(
    parameter int unsigned X_WIDTH   = 3,
    parameter int unsigned Y_WIDTH   = 3,
    parameter int unsigned P_WIDTH   = 6,
    parameter bit          SIGNED    = 1'b0,
    parameter bit          HAS_READY = 1'b1,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [X_WIDTH-1:0]     dut_x,
    output logic [Y_WIDTH-1:0]     dut_y,
    output logic                   dut_rst,
    input  logic [P_WIDTH-1:0]     dut_p,
    input  logic                   dut_s,
    input  logic                   dut_rdy,
    output logic                   busy,
    output logic                   done,
    output logic [ErrCntWidth-1:0] err_cnt,
    output logic                   timeout_seen,
    output logic                   fail_valid,
    output logic [X_WIDTH-1:0]     fail_x,
    output logic [Y_WIDTH-1:0]     fail_y
);

    localparam int unsigned WaitW = cnt_width(max_width(TIMEOUT, LATENCY));
    localparam logic [WaitW-1:0] WaitTimeout = WaitW'(TIMEOUT - 1);
    localparam logic [WaitW-1:0] WaitSample  = WaitW'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       wait_cnt_q;
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic                   timeout_seen_q;
    logic                   fail_valid_q;
    logic [X_WIDTH-1:0]     fail_x_q;
    logic [Y_WIDTH-1:0]     fail_y_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   in_wait;
    logic                   sweep_start;
    logic                   sample;
    logic                   timed_out;
    logic                   mismatch;
    logic                   vec_end;
    logic                   vec_err;
    logic                   last;
    logic [P_WIDTH-1:0]     exp_p;
    logic                   exp_s;

    mul_exr_vecgen #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .P_WIDTH (P_WIDTH),
        .SIGNED  (SIGNED)
    ) u_vecgen (
        .clk   (clk),
        .rst   (rst),
        .clear (sweep_start),
        .step  (vec_end && !last),
        .x     (dut_x),
        .y     (dut_y),
        .last  (last),
        .exp_p (exp_p),
        .exp_s (exp_s)
    );

    always_comb begin
        in_wait     = (state_q == StWait);
        sweep_start = start && ((state_q == StIdle) || (state_q == StDone));
        // The first WAIT cycle ignores ready so a ready left over from the last vector is rejected.
        if (HAS_READY) begin
            sample = in_wait && dut_rdy && (wait_cnt_q != '0);
        end else begin
            sample = in_wait && (wait_cnt_q == WaitSample);
        end
        timed_out = in_wait && !sample && (wait_cnt_q == WaitTimeout);
        if (SIGNED) begin
            mismatch = {dut_s, dut_p} != {exp_s, exp_p};
        end else begin
            mismatch = dut_p != exp_p;
        end
        vec_end = sample || timed_out;
        vec_err = (sample && mismatch) || timed_out;

        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (sweep_start) state_d = StLoad;
            StLoad:         state_d = StWait;
            StWait:         if (vec_end) state_d = last ? StDone : StLoad;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            err_cnt_q      <= '0;
            timeout_seen_q <= 1'b0;
            fail_valid_q   <= 1'b0;
            fail_x_q       <= '0;
            fail_y_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StLoad) || (state_d == StWait);
            done_q  <= (state_d == StDone);

            if (state_q == StLoad) begin
                wait_cnt_q <= '0;
            end else if (in_wait) begin
                wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end

            if (sweep_start) begin
                err_cnt_q      <= '0;
                timeout_seen_q <= 1'b0;
                fail_valid_q   <= 1'b0;
                fail_x_q       <= '0;
                fail_y_q       <= '0;
            end else if (vec_err) begin
                if (err_cnt_q != ErrCntMax) begin
                    err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
                end
                if (timed_out) begin
                    timeout_seen_q <= 1'b1;
                end
                if (!fail_valid_q) begin
                    fail_valid_q <= 1'b1;
                    fail_x_q     <= dut_x;
                    fail_y_q     <= dut_y;
                end
            end
        end
    end

    assign dut_rst      = rst || (state_q == StLoad);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_cnt      = err_cnt_q;
    assign timeout_seen = timeout_seen_q;
    assign fail_valid   = fail_valid_q;
    assign fail_x       = fail_x_q;
    assign fail_y       = fail_y_q;

endmodule

// File: tb/tb_mul_exerciser.sv
// Self-checking bench: behavioural multiplier cores with randomized ready latency and faults.
module tb_mul_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Unsigned instance, waits for ready.
    logic       u0_start, u0_drst, u0_s, u0_rdy, u0_busy, u0_done, u0_tmo, u0_fv;
    logic [2:0] u0_x, u0_y, u0_fx, u0_fy;
    logic [5:0] u0_p;
    logic [7:0] u0_err;

    // Signed instance, fixed latency of 3 WAIT cycles.
    logic       u1_start, u1_drst, u1_s, u1_rdy, u1_busy, u1_done, u1_tmo, u1_fv;
    logic [2:0] u1_x, u1_y, u1_fx, u1_fy;
    logic [5:0] u1_p;
    logic [7:0] u1_err;

    int checks = 0;
    int errors = 0;

    int         lat_tab [64];
    int         rdy_mode;
    logic [5:0] p_mask;
    logic       s_inv;
    int         cyc0;
    int         idx0;
    int         prod0;
    int         xs1, ys1;
    logic [6:0] pv1;

    mul_exerciser u0 (
        .clk (clk), .rst (rst), .start (u0_start),
        .dut_x (u0_x), .dut_y (u0_y), .dut_rst (u0_drst),
        .dut_p (u0_p), .dut_s (u0_s), .dut_rdy (u0_rdy),
        .busy (u0_busy), .done (u0_done), .err_cnt (u0_err),
        .timeout_seen (u0_tmo), .fail_valid (u0_fv), .fail_x (u0_fx), .fail_y (u0_fy)
    );

    mul_exerciser #(
        .SIGNED (1'b1), .HAS_READY (1'b0), .LATENCY (3)
    ) u1 (
        .clk (clk), .rst (rst), .start (u1_start),
        .dut_x (u1_x), .dut_y (u1_y), .dut_rst (u1_drst),
        .dut_p (u1_p), .dut_s (u1_s), .dut_rdy (u1_rdy),
        .busy (u1_busy), .done (u1_done), .err_cnt (u1_err),
        .timeout_seen (u1_tmo), .fail_valid (u1_fv), .fail_x (u1_fx), .fail_y (u1_fy)
    );

    // Unsigned core: ready in WAIT cycle lat_tab[vector], optional stuck-at-0 product bits.
    always @(posedge clk) begin
        if (u0_drst) cyc0 <= 0;
        else         cyc0 <= cyc0 + 1;
    end

    always_comb begin
        idx0  = int'({u0_y, u0_x});
        prod0 = int'(u0_x) * int'(u0_y);
        u0_p  = 6'(prod0) & ~p_mask;
        u0_s  = 1'b0;
        case (rdy_mode)
            0:       u0_rdy = 1'b0;
            1:       u0_rdy = 1'b1;
            default: u0_rdy = (cyc0 >= lat_tab[idx0] - 1);
        endcase
    end

    // Signed core from plain integer arithmetic.
    always_comb begin
        xs1    = int'(u1_x) - (u1_x[2] ? 8 : 0);
        ys1    = int'(u1_y) - (u1_y[2] ? 8 : 0);
        pv1    = 7'(xs1 * ys1);
        u1_p   = pv1[5:0];
        u1_s   = pv1[6] ^ s_inv;
        u1_rdy = 1'b0;
    end

    task automatic run_sweep(input bit sel, input bit poke, output int edges);
        int n;
        edges = -1;
        @(negedge clk);
        if (sel) u1_start = 1'b1;
        else     u0_start = 1'b1;
        @(posedge clk);
        #1;
        u0_start = 1'b0;
        u1_start = 1'b0;
        n = 0;
        while (edges < 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            u0_start = 1'b0;
            if ((sel && u1_done) || (!sel && u0_done)) edges = n;
            else if (poke && (n % 37 == 5)) u0_start = 1'b1;
        end
    endtask

    task automatic set_lat(input int lo, input int hi);
        for (int i = 0; i < 64; i++) lat_tab[i] = $urandom_range(hi, lo);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({u0_busy, u0_done, u0_tmo, u0_fv, u0_drst} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00001", {u0_busy, u0_done, u0_tmo, u0_fv, u0_drst});
        end
        checks++;
        if ({u0_err, u0_x, u0_y, u0_fx, u0_fy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0", {u0_err, u0_x, u0_y, u0_fx, u0_fy});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({u0_drst, u1_drst, u0_busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_dut_rst: got %b want 000", {u0_drst, u1_drst, u0_busy});
        end
    endtask

    task automatic test_random_ready;
        int edges, expect_edges;
        rdy_mode = 2;
        p_mask = '0;
        set_lat(2, 15);
        lat_tab[0]  = 15;  // ready on the timeout cycle: sample must win
        lat_tab[63] = 2;
        expect_edges = 0;
        for (int i = 0; i < 64; i++) expect_edges += 1 + lat_tab[i];
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (edges != expect_edges) begin
            errors++;
            $display("FAIL rand_ready_cycles: got %0d want %0d", edges, expect_edges);
        end
        checks++;
        if ({u0_err, u0_tmo, u0_fv} !== 10'h0) begin
            errors++;
            $display("FAIL rand_ready_clean: err %0d tmo %b fv %b want 0 0 0", u0_err, u0_tmo, u0_fv);
        end
    endtask

    task automatic test_fixed_ready3;
        int edges;
        rdy_mode = 2;
        p_mask = '0;
        set_lat(3, 3);
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (edges != 64 * 4) begin
            errors++;
            $display("FAIL ready3_cycles: got %0d want %0d", edges, 64 * 4);
        end
        checks++;
        if ({u0_err, u0_fv, u0_done, u0_busy} !== 11'b00000000010) begin
            errors++;
            $display("FAIL ready3_status: err %0d fv %b done %b busy %b", u0_err, u0_fv, u0_done, u0_busy);
        end
    endtask

    task automatic test_stuck_bit(input int b);
        int edges, exp_err, fx, fy;
        bit first;
        rdy_mode = 2;
        set_lat(2, 6);
        p_mask = 6'(1 << b);
        exp_err = 0;
        first = 1'b1;
        fx = 0;
        fy = 0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (((x * y) >> b) & 1) begin
                    exp_err++;
                    if (first) begin
                        fx = x;
                        fy = y;
                        first = 1'b0;
                    end
                end
            end
        end
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (edges < 0 || u0_err !== 8'(exp_err)) begin
            errors++;
            $display("FAIL stuck%0d_err_cnt: got %0d want %0d", b, u0_err, exp_err);
        end
        checks++;
        if ({u0_fv, u0_fx, u0_fy} !== {1'b1, 3'(fx), 3'(fy)}) begin
            errors++;
            $display("FAIL stuck%0d_first: fv %b x %0d y %0d want 1 %0d %0d", b, u0_fv, u0_fx,
                     u0_fy, fx, fy);
        end
        p_mask = '0;
    endtask

    task automatic test_timeout;
        int edges;
        rdy_mode = 0;
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (edges != 64 * 16) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want %0d", edges, 64 * 16);
        end
        checks++;
        if ({u0_err, u0_tmo, u0_fv, u0_fx, u0_fy} !== {8'd64, 1'b1, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL timeout_status: err %0d tmo %b fv %b x %0d y %0d want 64 1 1 0 0",
                     u0_err, u0_tmo, u0_fv, u0_fx, u0_fy);
        end
    endtask

    task automatic test_ready_tied;
        int edges;
        rdy_mode = 1;
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (edges != 64 * 3) begin
            errors++;
            $display("FAIL tied_ready_cycles: got %0d want %0d", edges, 64 * 3);
        end
        checks++;
        if ({u0_err, u0_tmo} !== 9'h0) begin
            errors++;
            $display("FAIL tied_ready_err: err %0d tmo %b want 0 0", u0_err, u0_tmo);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        rdy_mode = 2;
        set_lat(3, 3);
        p_mask = 6'h01;
        @(negedge clk);
        u0_start = 1'b1;
        @(negedge clk);
        u0_start = 1'b0;
        n = 0;
        while (idx0 != 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        // Vectors (1,1),(3,1),(5,1),(7,1) precede vector 20.
        checks++;
        if (n >= 500 || u0_err !== 8'd4) begin
            errors++;
            $display("FAIL mid_pre_reset_err: got %0d want 4 (waited %0d)", u0_err, n);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({u0_busy, u0_done, u0_fv, u0_err, u0_x, u0_y} !== 17'h0) begin
            errors++;
            $display("FAIL mid_reset_state: busy %b done %b fv %b err %0d x %0d y %0d", u0_busy,
                     u0_done, u0_fv, u0_err, u0_x, u0_y);
        end
        @(negedge clk);
        u0_start = 1'b1;
        @(posedge clk);
        #1;
        u0_start = 1'b0;
        checks++;
        if ({u0_busy, u0_drst, u0_x, u0_y} !== 8'b11000000) begin
            errors++;
            $display("FAIL mid_restart: busy %b dut_rst %b x %0d y %0d want 1 1 0 0", u0_busy,
                     u0_drst, u0_x, u0_y);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p_mask = '0;
    endtask

    task automatic test_back_to_back;
        int edges, n;
        rdy_mode = 2;
        set_lat(3, 3);
        run_sweep(1'b0, 1'b1, edges);
        checks++;
        if (edges != 64 * 4 || u0_err !== 8'd0) begin
            errors++;
            $display("FAIL busy_start_ignored: cycles %0d err %0d want 256 0", edges, u0_err);
        end
        p_mask = 6'h01;
        run_sweep(1'b0, 1'b0, edges);
        checks++;
        if (u0_err !== 8'd16) begin
            errors++;
            $display("FAIL faulty_run_err: got %0d want 16", u0_err);
        end
        p_mask = '0;
        @(negedge clk);
        u0_start = 1'b1;
        @(posedge clk);
        #1;
        u0_start = 1'b0;
        checks++;
        if ({u0_err, u0_fv, u0_tmo, u0_done, u0_busy} !== 12'b000000000001) begin
            errors++;
            $display("FAIL done_restart_clear: err %0d fv %b tmo %b done %b busy %b", u0_err, u0_fv,
                     u0_tmo, u0_done, u0_busy);
        end
        n = 0;
        while (!u0_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 64 * 4 || u0_err !== 8'd0) begin
            errors++;
            $display("FAIL done_rerun: cycles %0d err %0d want 256 0", n, u0_err);
        end
    endtask

    task automatic test_signed;
        int edges;
        s_inv = 1'b0;
        run_sweep(1'b1, 1'b0, edges);
        checks++;
        if (edges != 64 * 4 || u1_err !== 8'd0 || u1_fv !== 1'b0) begin
            errors++;
            $display("FAIL signed_clean: cycles %0d err %0d fv %b want 256 0 0", edges, u1_err, u1_fv);
        end
        s_inv = 1'b1;
        run_sweep(1'b1, 1'b0, edges);
        checks++;
        if ({u1_err, u1_fv, u1_tmo, u1_fx, u1_fy} !== {8'd64, 1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL signed_sign_fault: err %0d fv %b tmo %b x %0d y %0d want 64 1 0 0 0",
                     u1_err, u1_fv, u1_tmo, u1_fx, u1_fy);
        end
        s_inv = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        u0_start = 1'b0;
        u1_start = 1'b0;
        rdy_mode = 2;
        p_mask   = '0;
        s_inv    = 1'b0;
        for (int i = 0; i < 64; i++) lat_tab[i] = 3;
        test_reset();
        test_random_ready();
        test_fixed_ready3();
        test_stuck_bit(0);
        test_stuck_bit($urandom_range(5, 1));
        test_timeout();
        test_ready_tied();
        test_reset_mid();
        test_back_to_back();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
